rggen_host_if_axi4lite: RTL

RGGEN_HOST_IF_AXI4LITE -- requirements
Module: rggen_host_if_axi4lite

---
 rtl/rggen_host_if_axi4lite.sv | 115 +++++++++++
 1 files changed

// File: rtl/rggen_host_if_axi4lite.sv
// rggen_host_if_axi4lite: AXI4-Lite slave (aw/w/b/ar/r) to rggen command/response bus bridge, one access at a time
module rggen_host_if_axi4lite #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_awvalid,
  output logic                     o_awready,
  input  logic [ADDRESS_WIDTH-1:0] i_awaddr,
  input  logic                     i_wvalid,
  output logic                     o_wready,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  input  logic [STRB_WIDTH-1:0]    i_wstrb,
  output logic                     o_bvalid,
  input  logic                     i_bready,
  output logic [1:0]               o_bresp,
  input  logic                     i_arvalid,
  output logic                     o_arready,
  input  logic [ADDRESS_WIDTH-1:0] i_araddr,
  output logic                     o_rvalid,
  input  logic                     i_rready,
  output logic [DATA_WIDTH-1:0]    o_rdata,
  output logic [1:0]               o_rresp,
  output logic                     o_command_valid,
  output logic                     o_read,
  output logic                     o_write,
  output logic [ADDRESS_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0]    o_write_data,
  output logic [DATA_WIDTH-1:0]    o_write_mask,
  input  logic                     i_response_ready,
  input  logic [DATA_WIDTH-1:0]    i_read_data,
  input  logic [1:0]               i_status
);
  localparam int LSB = $clog2(STRB_WIDTH);
  typedef enum logic [1:0] {IDLE, COMMAND, RESPONSE} state_e;
  state_e state;
  logic prio;
  logic w_elig;
  logic grant_w;
  logic grant_r;
  logic unused;
  logic [1:0] resp;
  logic [DATA_WIDTH-1:0] mask;
  logic [ADDRESS_WIDTH-1:0] aw_addr;
  logic [ADDRESS_WIDTH-1:0] ar_addr;
  for (genvar i = 0; i < STRB_WIDTH; i++) begin : g_mask
    assign mask[8*i+:8] = {8{i_wstrb[i]}};
  end
  assign aw_addr = {i_awaddr[ADDRESS_WIDTH-1:LSB], {LSB{1'b0}}};
  assign ar_addr = {i_araddr[ADDRESS_WIDTH-1:LSB], {LSB{1'b0}}};
  assign resp = {i_status[0], 1'b0};
  assign unused = ^{i_status[1], i_awaddr[LSB-1:0], i_araddr[LSB-1:0]};
  // prio=0 favours the write when both directions are eligible; gated by rst so readies drop asynchronously
  assign w_elig = i_awvalid && i_wvalid;
  assign grant_w = !rst && state == IDLE && w_elig && (!i_arvalid || !prio);
  assign grant_r = !rst && state == IDLE && i_arvalid && (!w_elig || prio);
  assign o_awready = grant_w;
  assign o_wready = grant_w;
  assign o_arready = grant_r;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      prio <= 1'b0;
      o_command_valid <= 1'b0;
      o_write <= 1'b0;
      o_read <= 1'b0;
      o_address <= '0;
      o_write_data <= '0;
      o_write_mask <= '0;
      o_bvalid <= 1'b0;
      o_bresp <= 2'b00;
      o_rvalid <= 1'b0;
      o_rresp <= 2'b00;
      o_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (grant_w || grant_r) begin
          state <= COMMAND;
          o_command_valid <= 1'b1;
          o_write <= grant_w;
          o_read <= grant_r;
          o_address <= grant_w ? aw_addr : ar_addr;
          o_write_data <= grant_w ? i_wdata : '0;
          o_write_mask <= grant_w ? mask : '0;
        end
        COMMAND: if (i_response_ready) begin
          state <= RESPONSE;
          o_command_valid <= 1'b0;
          o_write <= 1'b0;
          o_read <= 1'b0;
          o_address <= '0;
          o_write_data <= '0;
          o_write_mask <= '0;
          o_bvalid <= o_write;
          o_rvalid <= o_read;
          o_bresp <= o_write ? resp : 2'b00;
          o_rresp <= o_read ? resp : 2'b00;
          o_rdata <= o_read ? i_read_data : '0;
        end
        RESPONSE: if ((o_bvalid && i_bready) || (o_rvalid && i_rready)) begin
          state <= IDLE;
          prio <= ~prio;
          o_bvalid <= 1'b0;
          o_rvalid <= 1'b0;
          o_bresp <= 2'b00;
          o_rresp <= 2'b00;
          o_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
